// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: merges board reset, clock-lock flags and a software
// request into N_OUT ordered, synchronously released active-low resets.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ASSERT     | all outputs low, enforcing the minimum reset pulse width
//   WAIT_LOCK  | outputs low, debouncing the synchronised AND of all locks
//   RELEASE    | releasing rst_n[0..N_OUT-1] one stage every STAGE_DELAY
//   RUN        | all outputs released, ready high
module rst_seq_ctrl #(
  parameter int N_LOCK          = 1,
  parameter int N_OUT           = 3,
  parameter int MIN_ASSERT      = 32,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int STAGE_DELAY     = 16
) (
  input  logic              hclk,
  input  logic              ext_reset_n,
  input  logic [N_LOCK-1:0] locked,
  input  logic              sw_reset_req,
  output logic [N_OUT-1:0]  rst_n,
  output logic              ready,
  output logic [1:0]        reset_cause,
  output logic [7:0]        reset_count
);

  localparam int AS_W = $clog2(MIN_ASSERT + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SD_W = $clog2(STAGE_DELAY + 1);
  localparam int IX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [1:0] ST_ASSERT    = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  logic [1:0]        rst_sync;
  logic              int_rst_n;
  logic [N_LOCK-1:0] lock_meta;
  logic [N_LOCK-1:0] lock_sync;
  logic              all_locked;
  logic [1:0]        state;
  logic [AS_W-1:0]   as_cnt;
  logic [DB_W-1:0]   db_cnt;
  logic [SD_W-1:0]   sd_cnt;
  logic [IX_W-1:0]   stage_idx;
  logic [N_OUT-1:0]  rst_q;
  logic              ready_q;
  logic [7:0]        count_inc;

  // Assertion is immediate, release is re-timed to hclk.
  always_ff @(posedge hclk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign int_rst_n = rst_sync[1];

  always_ff @(posedge hclk or negedge int_rst_n) begin
    if (!int_rst_n) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  assign all_locked = &lock_sync;
  assign count_inc  = (reset_count == 8'hFF) ? reset_count : reset_count + 8'd1;

  always_ff @(posedge hclk or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state       <= ST_ASSERT;
      as_cnt      <= '0;
      db_cnt      <= '0;
      sd_cnt      <= '0;
      stage_idx   <= '0;
      rst_q       <= '0;
      ready_q     <= 1'b0;
      reset_cause <= CAUSE_EXT;
      reset_count <= 8'd0;
    end else begin
      case (state)
        ST_ASSERT: begin
          db_cnt <= '0;
          if (sw_reset_req) begin
            as_cnt <= '0;
          end else if (as_cnt == AS_W'(MIN_ASSERT - 1)) begin
            as_cnt <= '0;
            state  <= ST_WAIT_LOCK;
          end else begin
            as_cnt <= as_cnt + AS_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (sw_reset_req) begin
            state       <= ST_ASSERT;
            db_cnt      <= '0;
            as_cnt      <= '0;
            reset_cause <= CAUSE_SW;
            reset_count <= count_inc;
          end else if (!all_locked) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
            state     <= ST_RELEASE;
            db_cnt    <= '0;
            sd_cnt    <= '0;
            stage_idx <= '0;
            rst_q     <= N_OUT'(1);
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!all_locked || sw_reset_req) begin
            // Lock loss takes priority when both arrive together.
            state       <= ST_ASSERT;
            as_cnt      <= '0;
            rst_q       <= '0;
            ready_q     <= 1'b0;
            reset_cause <= all_locked ? CAUSE_SW : CAUSE_LOCK;
            reset_count <= count_inc;
          end else if (state == ST_RELEASE) begin
            if (stage_idx == IX_W'(N_OUT - 1)) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
            end else if (sd_cnt == SD_W'(STAGE_DELAY - 1)) begin
              sd_cnt    <= '0;
              stage_idx <= stage_idx + IX_W'(1);
              rst_q     <= (rst_q << 1) | N_OUT'(1);
            end else begin
              sd_cnt <= sd_cnt + SD_W'(1);
            end
          end
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

  assign rst_n = rst_q;
  assign ready = ready_q;

endmodule
